// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the X9 program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } loader_state_t;

    localparam int IW_DEF  = 9;
    localparam int D_DEF   = 12;
    localparam int ERR_OVF = 0;
    localparam int ERR_SUM = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i && q_q != {W{1'b1}}) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then runs the X9 core and times it.
// Optional PROG_CHECKSUM_EN: XOR checksum of the program checked on the last word.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D        = D_DEF,
    parameter int IW       = IW_DEF,
    parameter int HOLD_CYC = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [IW-1:0] s_data,
    input  logic          s_last,
    input  logic [IW-1:0] exp_sum,
    input  logic          req,
    input  logic          core_done,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [IW-1:0] im_wr_dat,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic [D:0]    words,
    output logic [CW-1:0] cyc_cnt,
    output logic [1:0]    err
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    loader_state_t state_q, state_d;
    logic          s_ready_q, im_wr_en_q, core_rst_q, busy_q, done_q;
    logic [D-1:0]  im_addr_q;
    logic [IW-1:0] im_wr_dat_q;
    logic [D:0]    words_q, words_d;
    logic [1:0]    err_q, err_d;
    logic [HW-1:0] hold_cnt;
    logic [D-1:0]  idx;
    logic          accept, start, rerun, top, fin, ovf, bad, hold_end;

    assign accept = s_valid && s_ready_q;
    assign start  = accept && (state_q == IDLE || state_q == DONE);
    assign rerun  = req && !accept && state_q == DONE;
    assign idx    = start ? '0 : words_q[D-1:0];
    assign top    = (idx == {D{1'b1}});
    assign fin    = accept && (s_last || top);
    assign ovf    = accept && top && !s_last;

    // The write cycle itself is not part of the hold window.
    assign hold_end = state_q == HOLD && !im_wr_en_q
                      && hold_cnt == HW'(HOLD_CYC - 1);

`ifdef PROG_CHECKSUM_EN
    logic [IW-1:0] sum_q, sum_d;

    assign sum_d = (start ? '0 : sum_q) ^ s_data;
    assign bad   = accept && s_last && (sum_d != exp_sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_d;
        end
    end
`else
    logic unused_sum;

    assign unused_sum = ^exp_sum;
    assign bad        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = fin ? (bad ? DONE : HOLD) : LOAD;
        end else begin
            unique case (state_q)
                HOLD:    if (hold_end) state_d = RUN;
                RUN:     if (core_done) state_d = DONE;
                DONE:    if (req) state_d = HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (start) err_d = '0;
        if (ovf) err_d[ERR_OVF] = 1'b1;
        if (bad) err_d[ERR_SUM] = 1'b1;
        if (rerun) err_d[ERR_SUM] = 1'b0;
    end

    always_comb begin
        words_d = words_q;
        if (start) words_d = (D+1)'(1);
        else if (accept) words_d = words_q + 1'b1;
    end

    sat_counter #(.W(CW)) u_cyc (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (start || rerun),
        .en_i   (state_q == RUN && !core_done),
        .q_o    (cyc_cnt)
    );

    sat_counter #(.W(HW)) u_hold (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (state_q != HOLD),
        .en_i   (!im_wr_en_q),
        .q_o    (hold_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            im_wr_en_q  <= 1'b0;
            im_addr_q   <= '0;
            im_wr_dat_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            words_q     <= '0;
            err_q       <= '0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= state_d inside {IDLE, LOAD, DONE};
            busy_q     <= state_d inside {LOAD, HOLD, RUN};
            done_q     <= state_d == DONE;
            core_rst_q <= state_d != RUN;
            im_wr_en_q <= accept;
            if (accept) begin
                im_addr_q   <= idx;
                im_wr_dat_q <= s_data;
            end
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign im_wr_en  = im_wr_en_q;
    assign im_addr   = im_addr_q;
    assign im_wr_dat = im_wr_dat_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign words     = words_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: timestamp-based reference model plus directed and random loads.
module tb_prog_loader;

    localparam int TD  = 2;
    localparam int THC = 4;
`ifdef PROG_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_last = 1'b0, req = 1'b0, core_done = 1'b0;
    logic [8:0] s_data = '0, exp_sum = '0;
    logic s_ready, im_wr_en, core_rst, busy, done;
    logic [TD-1:0] im_addr;
    logic [8:0] im_wr_dat;
    logic [TD:0] words;
    logic [15:0] cyc_cnt;
    logic [1:0] err;

    bit noise_en = 1'b0, req_m = 1'b0, cd_m = 1'b0;
    int checks = 0, errors = 0;
    int wa[$];
    int wd[$];

    always #5 clk = ~clk;

    prog_loader #(.D(TD), .IW(9), .HOLD_CYC(THC), .CW(16)) dut (
        .clk(clk), .reset(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .exp_sum(exp_sum), .req(req),
        .core_done(core_done), .im_wr_en(im_wr_en), .im_addr(im_addr),
        .im_wr_dat(im_wr_dat), .core_rst(core_rst), .busy(busy),
        .done(done), .words(words), .cyc_cnt(cyc_cnt), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: tracks release time stamps rather than states.
    logic m_rdy, m_busy, m_done, m_rst, m_wen;
    logic [TD-1:0] m_addr;
    logic [8:0] m_wdat, m_sum;
    logic [TD:0] m_words;
    logic [15:0] m_cyc;
    logic [1:0] m_err;
    bit loading, holding, running, finished, acc, ovf, bad;
    int ecount, rel, idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy = 0; m_busy = 0; m_done = 0; m_rst = 1; m_wen = 0;
            m_addr = 0; m_wdat = 0; m_words = 0; m_cyc = 0; m_err = 0;
            m_sum = 0; loading = 0; holding = 0; running = 0;
            finished = 0; ecount = 0; rel = 0;
        end else begin
            ecount++;
            acc = s_valid && m_rdy;
            m_wen = acc;
            if (acc) begin
                if (!loading) begin
                    m_words = 0; m_err = 0; m_cyc = 0; m_sum = 0;
                    finished = 0;
                end
                idx = int'(m_words);
                m_addr = TD'(idx);
                m_wdat = s_data;
                m_words = m_words + 1;
                m_sum = m_sum ^ s_data;
                ovf = (idx == (1 << TD) - 1) && !s_last;
                if (ovf) m_err[0] = 1'b1;
                if (s_last || ovf) begin
                    loading = 0;
                    bad = CSUM && s_last && (m_sum != exp_sum);
                    if (bad) begin
                        m_err[1] = 1'b1;
                        finished = 1;
                    end else begin
                        holding = 1;
                        rel = ecount + THC + 1;
                    end
                end else begin
                    loading = 1;
                end
            end else if (running) begin
                if (core_done) begin
                    running = 0;
                    finished = 1;
                end else if (m_cyc != 16'hFFFF) begin
                    m_cyc = m_cyc + 1;
                end
            end else if (finished && req) begin
                m_cyc = 0;
                m_err[1] = 1'b0;
                finished = 0;
                holding = 1;
                rel = ecount + THC;
            end
            if (holding && ecount == rel) begin
                holding = 0;
                running = 1;
            end
            m_rdy = !(holding || running);
            m_busy = loading || holding || running;
            m_done = finished;
            m_rst = !running;
        end
    end

    always @(negedge clk) begin
        chk("s_ready", s_ready, m_rdy);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("core_rst", core_rst, m_rst);
        chk("im_wr_en", im_wr_en, m_wen);
        chk("im_addr", im_addr, m_addr);
        chk("im_wr_dat", im_wr_dat, m_wdat);
        chk("words", words, m_words);
        chk("cyc_cnt", cyc_cnt, m_cyc);
        chk("err", err, m_err);
        if (im_wr_en) begin
            wa.push_back(int'(im_addr));
            wd.push_back(int'(im_wr_dat));
        end
    end

    always @(posedge clk) begin
        #2;
        req = noise_en ? ($urandom % 7 == 0) : req_m;
        core_done = noise_en ? ($urandom % 5 == 0) : cd_m;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [8:0] d, input logic l,
                        input int budget, output logic ok);
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!ok) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (core_rst && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("release_seen", n < 60, 1);
        @(posedge clk);
        #1;
        tick(2);
        cd_m = 1'b1;
        tick(1);
        cd_m = 1'b0;
        @(negedge clk);
        chk("rtd_done", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic ok;
        int hi;
        tick(3);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_words", words, 0);
        rst_n = 1'b1;
        tick(1);

        // Three-word load, hold window, then a 10-cycle run.
        exp_sum = 9'h1A0 ^ 9'h0F3 ^ 9'h105;
        send(9'h1A0, 0, 20, ok);
        send(9'h0F3, 0, 20, ok);
        send(9'h105, 1, 20, ok);
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!core_rst) break;
            hi++;
        end
        chk("t1_hold_cycles", hi, 4);
        chk("t1_nwrites", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t1_addr0", wa[0], 0);
            chk("t1_addr1", wa[1], 1);
            chk("t1_addr2", wa[2], 2);
            chk("t1_dat0", wd[0], 'h1A0);
            chk("t1_dat2", wd[2], 'h105);
        end
        chk("t1_words", words, 3);
        chk("t1_model_words", m_words, 3);
        @(posedge clk);
        #1;
        tick(9);
        cd_m = 1'b1;
        tick(1);
        cd_m = 1'b0;
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        chk("t2_cyc", cyc_cnt, 10);
        chk("t2_model_cyc", m_cyc, 10);
        chk("t2_core_rst", core_rst, 1);

        // Re-run without reloading.
        @(posedge clk);
        #1;
        req_m = 1'b1;
        tick(1);
        req_m = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!core_rst) break;
            hi++;
        end
        chk("t3_hold_cycles", hi, 4);
        chk("t3_no_writes", wa.size(), 3);
        chk("t3_cyc_restart", cyc_cnt, 0);
        @(posedge clk);
        #1;
        cd_m = 1'b1;
        tick(1);
        cd_m = 1'b0;
        @(negedge clk);
        chk("t3_cyc", cyc_cnt, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a load.
        wa.delete();
        wd.delete();
        send(9'h011, 0, 20, ok);
        send(9'h022, 0, 20, ok);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t4_s_ready", s_ready, 0);
        chk("t4_words", words, 0);
        chk("t4_core_rst", core_rst, 1);
        chk("t4_busy", busy, 0);
        chk("t4_wr_en", im_wr_en, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        exp_sum = 9'h033 ^ 9'h044 ^ 9'h055;
        send(9'h033, 0, 20, ok);
        @(negedge clk);
        chk("t4_wr_en1", im_wr_en, 1);
        chk("t4_addr0", im_addr, 0);
        chk("t4_words1", words, 1);
        @(posedge clk);
        #1;
        send(9'h044, 0, 20, ok);
        send(9'h055, 1, 20, ok);
        run_to_done();

        // Address overflow with a 2-bit address.
        wa.delete();
        wd.delete();
        for (int i = 0; i < 4; i++) send(9'(9'h100 + i), 0, 20, ok);
        @(negedge clk);
        chk("t5_s_ready", s_ready, 0);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 1);
        chk("t5_words", words, 4);
        @(posedge clk);
        #1;
        send(9'h1FF, 0, 3, ok);
        chk("t5_blocked", ok, 0);
        chk("t5_nwrites", wa.size(), 4);
        if (wa.size() == 4) chk("t5_addr3", wa[3], 3);
        run_to_done();

`ifdef PROG_CHECKSUM_EN
        exp_sum = 9'h007;
        send(9'h003, 0, 20, ok);
        send(9'h005, 1, 20, ok);
        @(negedge clk);
        chk("t6_err", err, 2);
        chk("t6_done", done, 1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!core_rst) hi++;
        end
        chk("t6_never_released", hi, 0);
        chk("t6_cyc", cyc_cnt, 0);
        @(posedge clk);
        #1;
        exp_sum = 9'h006;
        send(9'h003, 0, 20, ok);
        send(9'h005, 1, 20, ok);
        run_to_done();
        chk("t6_err_ok", err, 0);
`endif

        // Random programs with background req / core_done noise.
        for (int it = 0; it < 40; it++) begin
            int len;
            logic [8:0] x, d;
            bit dorst, seen;
            noise_en = 1'b1;
            len = 1 + int'($urandom % 5);
            x = '0;
            dorst = ($urandom % 8) == 0;
            for (int i = 0; i < len; i++) begin
                d = 9'($urandom);
                x = x ^ d;
                exp_sum = ($urandom % 3 == 0) ? 9'($urandom) : x;
                tick(int'($urandom % 3));
                send(d, i == len - 1, 200, ok);
                chk("rnd_accept", ok, 1);
                if (dorst) begin
                    #2 rst_n = 1'b0;
                    @(posedge clk);
                    #1 rst_n = 1'b1;
                    break;
                end
                if (i == 3) break;
            end
            if (!dorst) begin
                seen = 0;
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (done) begin
                        seen = 1;
                        break;
                    end
                end
                chk("rnd_done_seen", seen, 1);
                @(posedge clk);
                #1;
            end
        end

        // Park in DONE, then check cycle-counter saturation.
        noise_en = 1'b0;
        req_m = 1'b0;
        cd_m = 1'b1;
        tick(12);
        cd_m = 1'b0;
        exp_sum = 9'h0AA;
        send(9'h0AA, 1, 50, ok);
        chk("sat_accept", ok, 1);
        hi = 0;
        while (core_rst && hi < 60) begin
            @(negedge clk);
            hi++;
        end
        @(posedge clk);
        #1;
        tick(65540);
        @(negedge clk);
        chk("sat_cyc", cyc_cnt, 16'hFFFF);
        chk("sat_busy", busy, 1);
        @(posedge clk);
        #1;
        cd_m = 1'b1;
        tick(1);
        cd_m = 1'b0;
        @(negedge clk);
        chk("sat_done", done, 1);
        chk("sat_cyc_frozen", cyc_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
